// File: rtl/i2c_pkg.sv
// Shared types and line-level constants for the I2C register target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings raw SCL/SDA into the clk domain and derives edge and START/STOP pulses.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic r_scl_m, r_scl_s, r_scl_h;
  logic r_sda_m, r_sda_s, r_sda_h;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_m <= 1'b1;
      r_scl_s <= 1'b1;
      r_scl_h <= 1'b1;
      r_sda_m <= 1'b1;
      r_sda_s <= 1'b1;
      r_sda_h <= 1'b1;
    end else begin
      r_scl_m <= scl_in;
      r_scl_s <= r_scl_m;
      r_scl_h <= r_scl_s;
      r_sda_m <= sda_in;
      r_sda_s <= r_sda_m;
      r_sda_h <= r_sda_s;
    end
  end

  assign scl_rise  = r_scl_s & ~r_scl_h;
  assign scl_fall  = ~r_scl_s & r_scl_h;
  // SCL must be high on both samples so an SCL edge never looks like START/STOP.
  assign start_det = r_scl_s & r_scl_h & r_sda_h & ~r_sda_s;
  assign stop_det  = r_scl_s & r_scl_h & ~r_sda_h & r_sda_s;
  assign sda_s     = r_sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target backed by a byte-wide register file with an auto-incrementing pointer.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         DEPTH       = 16,
  parameter int         AW          = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_index,
  output logic [7:0]    wr_data,
  input  logic [AW-1:0] loc_addr,
  output logic [7:0]    loc_rdata
);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop),
    .sda_s     (w_sda)
  );

  i2c_state_t    r_state, w_state_nxt;
  logic [2:0]    r_cnt, w_cnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [6:0]    r_tx, w_tx_nxt;
  logic [AW-1:0] r_ptr, w_ptr_nxt;
  logic          r_byte_done, w_done_nxt;
  logic          r_sda_oe, w_oe_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_wr_strobe;
  logic [AW-1:0] r_wr_index;
  logic [7:0]    r_wr_data;
  logic [7:0]    r_loc_rdata;
  logic [7:0]    r_regs [DEPTH];

  logic          w_wr_en;
  logic [7:0]    w_shift_in;
  logic [7:0]    w_cur_byte;

  assign w_shift_in = {r_shift[6:0], w_sda};
  assign w_cur_byte = r_regs[r_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_tx        <= '0;
      r_ptr       <= '0;
      r_byte_done <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_index  <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_tx        <= w_tx_nxt;
      r_ptr       <= w_ptr_nxt;
      r_byte_done <= w_done_nxt;
      r_sda_oe    <= w_oe_nxt;
      r_busy      <= w_busy_nxt;
      r_wr_strobe <= w_wr_en;
      if (w_wr_en) begin
        r_wr_index <= r_ptr;
        r_wr_data  <= w_shift_in;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_ptr_nxt   = r_ptr;
    w_done_nxt  = r_byte_done;
    w_oe_nxt    = r_sda_oe;
    w_busy_nxt  = r_busy;
    w_wr_en     = 1'b0;

    if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_done_nxt  = 1'b0;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt = ST_ADDR;
      w_cnt_nxt   = '0;
      w_done_nxt  = 1'b0;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (w_scl_rise && !r_byte_done) begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_done_nxt = 1'b1;
              if (r_state == ST_WDATA) begin
                w_wr_en   = 1'b1;
                w_ptr_nxt = r_ptr + AW'(1);
              end
            end
          end else if (w_scl_fall && r_byte_done) begin
            w_done_nxt = 1'b0;
            w_oe_nxt   = 1'b1;
            if (r_state == ST_ADDR) begin
              if (r_shift[7:1] == TARGET_ADDR) begin
                w_busy_nxt  = 1'b1;
                w_state_nxt = ST_ADDR_ACK;
              end else begin
                w_oe_nxt    = 1'b0;
                w_state_nxt = ST_IGNORE;
              end
            end else if (r_state == ST_PTR) begin
              w_ptr_nxt   = r_shift[AW-1:0];
              w_state_nxt = ST_PTR_ACK;
            end else begin
              w_state_nxt = ST_WDATA_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_oe_nxt  = 1'b0;
            w_cnt_nxt = '0;
            if (r_shift[0] == I2C_RW_READ) begin
              w_tx_nxt    = w_cur_byte[6:0];
              w_oe_nxt    = ~w_cur_byte[7];
              w_state_nxt = ST_RDATA;
            end else begin
              w_state_nxt = ST_PTR;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            w_oe_nxt    = 1'b0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WDATA;
          end
        end
        ST_RDATA: begin
          // Bit 7 went out on entry; each fall here presents the next bit, the 8th releases.
          if (w_scl_fall) begin
            if (r_cnt == 3'd7) begin
              w_oe_nxt    = 1'b0;
              w_cnt_nxt   = '0;
              w_done_nxt  = 1'b0;
              w_state_nxt = ST_RDATA_ACK;
            end else begin
              w_oe_nxt  = ~r_tx[6];
              w_tx_nxt  = {r_tx[5:0], 1'b0};
              w_cnt_nxt = r_cnt + 3'd1;
            end
          end
        end
        ST_RDATA_ACK: begin
          if (w_scl_rise) begin
            if (w_sda == ACK) begin
              w_ptr_nxt  = r_ptr + AW'(1);
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_IGNORE;
            end
          end else if (w_scl_fall && r_byte_done) begin
            w_done_nxt  = 1'b0;
            w_cnt_nxt   = '0;
            w_tx_nxt    = w_cur_byte[6:0];
            w_oe_nxt    = ~w_cur_byte[7];
            w_state_nxt = ST_RDATA;
          end
        end
        default: begin
          w_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  // Local read samples the array before this cycle's bus write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_loc_rdata <= '0;
    end else begin
      if (w_wr_en) r_regs[r_ptr] <= w_shift_in;
      r_loc_rdata <= r_regs[loc_addr];
    end
  end

  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign wr_strobe = r_wr_strobe;
  assign wr_index  = r_wr_index;
  assign wr_data   = r_wr_data;
  assign loc_rdata = r_loc_rdata;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bus-master bench for i2c_target_regs: vector table, directed corner cases, random traffic vs model.
module tb_i2c_target_regs;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int Q     = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m_scl = 1'b1;
  logic          m_sda = 1'b1;
  logic [AW-1:0] loc_addr = '0;
  logic          sda_oe, busy, wr_strobe;
  logic [AW-1:0] wr_index;
  logic [7:0]    wr_data, loc_rdata;
  logic          sda_line;

  assign sda_line = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs #(.TARGET_ADDR(7'h50), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (m_scl),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_index  (wr_index),
    .wr_data   (wr_data),
    .loc_addr  (loc_addr),
    .loc_rdata (loc_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0] st_idx_q[$];
  logic [7:0]    st_dat_q[$];
  logic [7:0]    st_loc_q[$];
  logic [7:0]    loc_next_q[$];
  logic          prev_strobe = 1'b0;
  int            oe_cnt = 0;
  int            busy_cnt = 0;

  always @(negedge clk) begin
    if (wr_strobe) begin
      st_idx_q.push_back(wr_index);
      st_dat_q.push_back(wr_data);
      st_loc_q.push_back(loc_rdata);
    end
    if (prev_strobe) loc_next_q.push_back(loc_rdata);
    prev_strobe = wr_strobe;
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  logic [7:0] mregs [DEPTH];
  int         mptr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wq(1);
    m_scl = 1'b1; wq(1);
    m_sda = 1'b0; wq(1);
    m_scl = 1'b0; wq(1);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wq(1);
    m_scl = 1'b1; wq(1);
    m_sda = 1'b1; wq(1);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda = b[i]; wq(1);
      m_scl = 1'b1; wq(2);
      m_scl = 1'b0;
    end
    wq(1);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    m_sda = 1'b1; wq(1);
    m_scl = 1'b1; wq(1);
    ack = sda_line; wq(1);
    m_scl = 1'b0; wq(1);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic ack_bit);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; wq(1);
      m_scl = 1'b1; wq(1);
      b[i] = sda_line; wq(1);
      m_scl = 1'b0; wq(1);
    end
    m_sda = ack_bit; wq(1);
    m_scl = 1'b1; wq(2);
    m_scl = 1'b0; wq(1);
    m_sda = 1'b1;
  endtask

  task automatic loc_read(input logic [AW-1:0] idx, output logic [7:0] v);
    loc_addr = idx;
    @(negedge clk);
    v = loc_rdata;
  endtask

  typedef struct {
    logic [7:0]    addr_byte;
    logic [7:0]    ptr;
    logic [7:0]    d0;
    logic [7:0]    d1;
    logic          acked;
    logic [AW-1:0] idx0;
    logic [AW-1:0] idx1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic       acks[4];
    logic       a;
    logic [7:0] rb, p;
    logic [7:0] wbytes[$];
    int         base, nbase, oe0, b0, len, eidx;

    for (int i = 0; i < DEPTH; i++) mregs[i] = 8'h00;

    vecs[0] = '{8'hA0, 8'h03, 8'hAA, 8'h55, 1'b1, 4'd3,  4'd4};
    vecs[1] = '{8'hA2, 8'h03, 8'h12, 8'h34, 1'b0, 4'd0,  4'd0};
    vecs[2] = '{8'hA0, 8'h10, 8'h11, 8'h22, 1'b1, 4'd0,  4'd1};
    vecs[3] = '{8'hA0, 8'h0F, 8'h77, 8'h88, 1'b1, 4'd15, 4'd0};

    repeat (4) @(negedge clk);
    chk("rst sda_oe", sda_oe, 0);
    chk("rst busy", busy, 0);
    chk("rst wr_strobe", wr_strobe, 0);
    chk("rst wr_index", wr_index, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst loc_rdata", loc_rdata, 0);
    reset = 1'b0;
    wq(2);

    for (int v = 0; v < 4; v++) begin
      loc_addr = vecs[v].idx0;
      @(negedge clk);
      base  = st_idx_q.size();
      nbase = loc_next_q.size();
      oe0   = oe_cnt;
      b0    = busy_cnt;
      bus_start();
      send_byte(vecs[v].addr_byte, acks[0]);
      send_byte(vecs[v].ptr, acks[1]);
      send_byte(vecs[v].d0, acks[2]);
      send_byte(vecs[v].d1, acks[3]);
      bus_stop();
      wq(2);
      for (int i = 0; i < 4; i++)
        chk($sformatf("v%0d ack%0d", v, i), acks[i], vecs[v].acked ? 0 : 1);
      chk($sformatf("v%0d strobes", v), st_idx_q.size() - base, vecs[v].acked ? 2 : 0);
      chk($sformatf("v%0d sda_oe seen", v), oe_cnt != oe0, vecs[v].acked);
      chk($sformatf("v%0d busy seen", v), busy_cnt != b0, vecs[v].acked);
      chk($sformatf("v%0d busy after stop", v), busy, 0);
      if (vecs[v].acked) begin
        chk($sformatf("v%0d idx0", v), st_idx_q[base], vecs[v].idx0);
        chk($sformatf("v%0d dat0", v), st_dat_q[base], vecs[v].d0);
        chk($sformatf("v%0d idx1", v), st_idx_q[base+1], vecs[v].idx1);
        chk($sformatf("v%0d dat1", v), st_dat_q[base+1], vecs[v].d1);
        chk($sformatf("v%0d collide old", v), st_loc_q[base], mregs[vecs[v].idx0]);
        chk($sformatf("v%0d collide new", v), loc_next_q[nbase], vecs[v].d0);
        mregs[vecs[v].idx0] = vecs[v].d0;
        mregs[vecs[v].idx1] = vecs[v].d1;
        mptr = (int'(vecs[v].idx1) + 1) % DEPTH;
        loc_read(vecs[v].idx0, rb);
        chk($sformatf("v%0d loc idx0", v), rb, vecs[v].d0);
        loc_read(vecs[v].idx1, rb);
        chk($sformatf("v%0d loc idx1", v), rb, vecs[v].d1);
      end else begin
        loc_read(4'd3, rb);
        chk($sformatf("v%0d loc untouched", v), rb, mregs[3]);
      end
    end

    // Pointer-only write, repeated START, two-byte read (ACK then NACK).
    oe0 = oe_cnt;
    bus_start();
    send_byte(8'hA0, a); chk("rd addrW ack", a, 0);
    send_byte(8'h03, a); chk("rd ptr ack", a, 0);
    mptr = 3;
    bus_start();
    send_byte(8'hA1, a); chk("rd addrR ack", a, 0);
    chk("rd busy", busy, 1);
    recv_byte(rb, 1'b0); chk("rd byte0", rb, mregs[mptr]);
    chk("rd byte0 spec", rb, 8'hAA);
    mptr = (mptr + 1) % DEPTH;
    recv_byte(rb, 1'b1); chk("rd byte1", rb, mregs[mptr]);
    chk("rd byte1 spec", rb, 8'h55);
    wq(1);
    chk("rd released", sda_oe, 0);
    b0 = oe_cnt;
    send_byte(8'h00, a);
    chk("ignore no drive", oe_cnt - b0, 0);
    bus_stop();
    wq(2);
    chk("ignore busy cleared", busy, 0);
    bus_start();
    send_byte(8'hA1, a); chk("rd2 addr ack", a, 0);
    recv_byte(rb, 1'b1); chk("rd2 ptr kept", rb, mregs[mptr]);
    bus_stop();
    wq(2);

    // STOP after four bits of a data byte.
    base = st_idx_q.size();
    bus_start();
    send_byte(8'hA0, a); chk("part addr ack", a, 0);
    send_byte(8'h05, a); chk("part ptr ack", a, 0);
    mptr = 5;
    send_bits(8'hF0, 4);
    bus_stop();
    wq(2);
    chk("part no strobe", st_idx_q.size() - base, 0);
    chk("part sda_oe", sda_oe, 0);
    chk("part busy", busy, 0);
    loc_read(4'd5, rb);
    chk("part reg5", rb, mregs[5]);

    // Random traffic against the model.
    for (int it = 0; it < 16; it++) begin
      len = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 0) begin
        p = 8'($urandom_range(0, 255));
        wbytes.delete();
        base = st_idx_q.size();
        bus_start();
        send_byte(8'hA0, a); chk($sformatf("rw%0d addr ack", it), a, 0);
        send_byte(p, a);     chk($sformatf("rw%0d ptr ack", it), a, 0);
        for (int k = 0; k < len; k++) begin
          wbytes.push_back(8'($urandom_range(0, 255)));
          send_byte(wbytes[k], a);
          chk($sformatf("rw%0d d%0d ack", it, k), a, 0);
        end
        bus_stop();
        wq(2);
        chk($sformatf("rw%0d strobes", it), st_idx_q.size() - base, len);
        mptr = int'(p) % DEPTH;
        for (int k = 0; k < len; k++) begin
          eidx = mptr;
          chk($sformatf("rw%0d idx%0d", it, k), st_idx_q[base+k], eidx);
          chk($sformatf("rw%0d dat%0d", it, k), st_dat_q[base+k], wbytes[k]);
          mregs[eidx] = wbytes[k];
          mptr = (mptr + 1) % DEPTH;
        end
      end else begin
        bus_start();
        send_byte(8'hA1, a); chk($sformatf("rr%0d addr ack", it), a, 0);
        for (int k = 0; k < len; k++) begin
          recv_byte(rb, (k == len - 1) ? 1'b1 : 1'b0);
          chk($sformatf("rr%0d b%0d", it, k), rb, mregs[mptr]);
          if (k != len - 1) mptr = (mptr + 1) % DEPTH;
        end
        bus_stop();
        wq(2);
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      loc_read(AW'(i), rb);
      chk($sformatf("sweep %0d", i), rb, mregs[i]);
    end

    // Reset while the target is pulling SDA low for a 0 read bit.
    bus_start();
    send_byte(8'hA0, a);
    send_byte(8'h08, a);
    send_byte(8'h12, a); chk("rst prep ack", a, 0);
    bus_stop();
    mregs[8] = 8'h12;
    wq(1);
    bus_start();
    send_byte(8'hA0, a);
    send_byte(8'h08, a);
    bus_start();
    send_byte(8'hA1, a); chk("rst rd addr ack", a, 0);
    chk("rst driving 0", sda_oe, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst oe released", sda_oe, 0);
    chk("rst busy clear", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) mregs[i] = 8'h00;
    mptr = 0;
    m_scl = 1'b1;
    wq(1);
    m_sda = 1'b1;
    wq(2);
    loc_read(4'd8, rb);
    chk("rst reg8 cleared", rb, mregs[8]);
    loc_read(4'd3, rb);
    chk("rst reg3 cleared", rb, mregs[3]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
